// File: rtl/mod_frame_arbiter_pkg.sv
// Shared types, default configuration and the round-robin pick for the frame arbiter.
package mod_arb_pkg;

  localparam int DEF_NB_REQ     = 4;
  localparam int DEF_IN_LENGTH  = 16;
  localparam int DEF_OUT_LENGTH = 32;
  localparam int DEF_TAG_DEPTH  = 4;

  localparam int TAG_W = $clog2(DEF_NB_REQ);
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= 32).
  function automatic int unsigned rr_pick(input logic [31:0] valid,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      idx = (ptr + k) % n;
      if (k < n && !found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mod_frame_arbiter_if.sv
// Bus between the arbiter (master) and the shared frame-processing module (slave).
interface mod_frame_arbiter_if
  import mod_arb_pkg::*;
#(
  parameter int IN_LENGTH  = DEF_IN_LENGTH,
  parameter int OUT_LENGTH = DEF_OUT_LENGTH
);
  logic [0:IN_LENGTH-1][31:0]  mod_idata;
  logic                        mod_ien;
  logic                        mod_ien_data;
  logic                        mod_fct;
  logic                        mod_full;
  logic [0:OUT_LENGTH-1][31:0] mod_odata;
  logic                        mod_oen;

  modport master (
    output mod_idata, mod_ien, mod_ien_data, mod_fct,
    input  mod_full, mod_odata, mod_oen
  );

  modport slave (
    input  mod_idata, mod_ien, mod_ien_data, mod_fct,
    output mod_full, mod_odata, mod_oen
  );
endinterface

// File: rtl/mod_frame_arbiter_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every frame currently inside mod.
module mod_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by the pointers, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mod_frame_arbiter.sv
// Round-robin arbiter sharing one frame-processing module among NB_REQ requesters, returning results in order.
module mod_frame_arbiter
  import mod_arb_pkg::*;
#(
  parameter int NB_REQ     = DEF_NB_REQ,
  parameter int IN_LENGTH  = DEF_IN_LENGTH,
  parameter int OUT_LENGTH = DEF_OUT_LENGTH,
  parameter int TAG_DEPTH  = DEF_TAG_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_run,
  input  logic [NB_REQ-1:0]                      req_valid,
  input  logic [0:NB_REQ-1][0:IN_LENGTH-1][31:0] req_data,
  output logic [NB_REQ-1:0]                      req_ready,
  mod_frame_arbiter_if.master                    mod_bus,
  output logic [NB_REQ-1:0]                      rsp_valid,
  output logic [0:OUT_LENGTH-1][31:0]            rsp_data,
  output logic [$clog2(TAG_DEPTH):0]             inflight,
  output logic                                   err_orphan
);
  localparam int TW = $clog2(NB_REQ);
  localparam logic [NB_REQ-1:0] ONE_HOT0 = NB_REQ'(1);

  state_t                      state_q, state_d;
  logic [TW-1:0]               winner_q, winner_d;
  logic [TW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [0:IN_LENGTH-1][31:0]  mod_idata_q;
  logic                        mod_fct_q;
  logic [NB_REQ-1:0]           rsp_valid_q;
  logic [0:OUT_LENGTH-1][31:0] rsp_data_q;
  logic                        err_orphan_q;

  logic          tag_push, tag_pop, tag_empty, tag_full;
  logic [TW-1:0] tag_head;
  logic          can_grant;

  mod_tag_fifo #(
    .WIDTH (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (winner_q),
    .pop   (tag_pop),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (inflight)
  );

  // A full tag FIFO means TAG_DEPTH frames are already inside mod.
  assign can_grant = cfg_run && (|req_valid) && !mod_bus.mod_full && !tag_full;
  assign tag_push  = (state_q == GRANT);
  assign tag_pop   = mod_bus.mod_oen && !tag_empty;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (can_grant) begin
          winner_d = TW'(rr_pick(32'(req_valid), 32'(rr_ptr_q), NB_REQ));
          state_d  = GRANT;
        end
      end
      GRANT: state_d = ISSUE;
      ISSUE: begin
        rr_ptr_d = (winner_q == TW'(NB_REQ-1)) ? '0 : winner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      winner_q     <= '0;
      rr_ptr_q     <= '0;
      mod_idata_q  <= '0;
      mod_fct_q    <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      mod_fct_q   <= cfg_run;
      rsp_valid_q <= '0;
      if (state_q == GRANT) mod_idata_q <= req_data[winner_q];
      if (tag_pop) begin
        rsp_valid_q <= ONE_HOT0 << tag_head;
        rsp_data_q  <= mod_bus.mod_odata;
      end
      // A result with no outstanding tag cannot be routed; flag it and drop it.
      if (mod_bus.mod_oen && tag_empty) err_orphan_q <= 1'b1;
    end
  end

  assign req_ready            = (state_q == GRANT) ? (ONE_HOT0 << winner_q) : '0;
  assign mod_bus.mod_idata    = mod_idata_q;
  assign mod_bus.mod_ien      = (state_q == ISSUE);
  assign mod_bus.mod_ien_data = (state_q == ISSUE);
  assign mod_bus.mod_fct      = mod_fct_q;
  assign rsp_valid            = rsp_valid_q;
  assign rsp_data             = rsp_data_q;
  assign err_orphan           = err_orphan_q;

endmodule
